// File: rtl/pass_check_pkg.sv
// State and stage encodings shared by the password sequencer and its bench.
package pass_check_pkg;

    localparam int PW_W_DEF = 3;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE = 3'd0;
    localparam state_t ST_S1   = 3'd1;
    localparam state_t ST_S2   = 3'd2;
    localparam state_t ST_S3   = 3'd3;
    localparam state_t ST_OPEN = 3'd4;
    localparam state_t ST_LOCK = 3'd5;

    localparam logic [1:0] STG_IDLE = 2'd0;
    localparam logic [1:0] STG_D1   = 2'd1;
    localparam logic [1:0] STG_D2   = 2'd2;
    localparam logic [1:0] STG_D3   = 2'd3;

    // The password registers match on this index, so only digit states map to non-zero.
    function automatic logic [1:0] stage_of(input state_t st);
        case (st)
            ST_S1:            return STG_D1;
            ST_S2:            return STG_D2;
            ST_S3:            return STG_D3;
            ST_OPEN, ST_LOCK: return STG_IDLE;
            default:          return STG_IDLE;
        endcase
    endfunction

endpackage

// File: rtl/pass_check_if.sv
// Switch/button inputs, stored codes and lock/LED outputs of the password sequencer.
interface pass_check_if
    import pass_check_pkg::*;
#(
    parameter int PW_W = PW_W_DEF
);
    logic [PW_W-1:0] D;
    logic            EN;
    logic            CREATE;
    logic [PW_W-1:0] PW1;
    logic [PW_W-1:0] PW2;
    logic [PW_W-1:0] PW3;
    logic [1:0]      STAGE;
    logic            UNLOCKED;
    logic            FAIL;
    logic [1:0]      FAIL_CNT;
    logic            LOCKED_OUT;

    modport slave (
        input  D, EN, CREATE, PW1, PW2, PW3,
        output STAGE, UNLOCKED, FAIL, FAIL_CNT, LOCKED_OUT
    );

    modport master (
        output D, EN, CREATE, PW1, PW2, PW3,
        input  STAGE, UNLOCKED, FAIL, FAIL_CNT, LOCKED_OUT
    );
endinterface

// File: rtl/pass_check_btn_sync_edge.sv
// Enter-button synchronizer: 2 sync flops + history flop, registered one-cycle rise/release pulses.
// An EN fall before edge k gives o_rel high in the cycle after edge k+2.
module btn_sync_edge (
    input  logic CLK,
    input  logic RST,
    input  logic i_btn,
    output logic o_rise,
    output logic o_rel
);
    logic r_s1;
    logic r_s2;
    logic r_s3;
    logic r_rise;
    logic r_rel;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_s1   <= 1'b0;
            r_s2   <= 1'b0;
            r_s3   <= 1'b0;
            r_rise <= 1'b0;
            r_rel  <= 1'b0;
        end else begin
            r_s1   <= i_btn;
            r_s2   <= r_s1;
            r_s3   <= r_s2;
            r_rise <= r_s2 & ~r_s3;
            r_rel  <= ~r_s2 & r_s3;
        end
    end

    assign o_rise = r_rise;
    assign o_rel  = r_rel;
endmodule

// File: rtl/pass_check.sv
// Password entry sequencer: create walk / verify compare; outputs update 3 edges after an EN release.
// LOCKOUT_TIMER_EN adds a LOCK state held for LOCK_CYCLES after MAX_FAILS failures.
module pass_check
    import pass_check_pkg::*;
#(
    parameter int PW_W      = PW_W_DEF,
    parameter int MAX_FAILS = 3
`ifdef LOCKOUT_TIMER_EN
    ,
    parameter int LOCK_CYCLES = 500_000_000
`endif
) (
    input  logic          CLK,
    input  logic          RST,
    pass_check_if.slave   bus
);
    localparam logic [1:0] MAX_CNT = 2'(MAX_FAILS);

    logic            w_rise;
    logic            w_rel;
    logic            w_press;
    logic            w_locked;
    logic [PW_W-1:0] w_pw_sel;
    state_t          w_adv;
    logic            w_mm;
    logic [1:0]      w_cnt_inc;

    state_t          r_state;
    logic            r_mismatch;
    logic            r_fail;
    logic [1:0]      r_fail_cnt;
    logic            r_create_q;
    logic            r_mode;
    logic            r_armed;

    btn_sync_edge u_en_sync (
        .CLK    (CLK),
        .RST    (RST),
        .i_btn  (bus.EN),
        .o_rise (w_rise),
        .o_rel  (w_rel)
    );

`ifdef LOCKOUT_TIMER_EN
    localparam int LCW = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;

    logic [LCW-1:0] r_lock_cnt;
    logic           w_lock_done;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_lock_cnt <= '0;
        end else if (r_state != ST_LOCK) begin
            r_lock_cnt <= '0;
        end else begin
            r_lock_cnt <= r_lock_cnt + 1'b1;
        end
    end

    assign w_locked    = (r_state == ST_LOCK);
    assign w_lock_done = w_locked && (r_lock_cnt == LCW'(LOCK_CYCLES - 1));
`else
    assign w_locked = 1'b0;
`endif

    // A press only counts if it began outside lockout, so a button held across
    // the end of a lockout cannot sneak in a release.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_armed <= 1'b0;
        end else if (w_rise) begin
            r_armed <= ~w_locked;
        end else if (w_rel) begin
            r_armed <= 1'b0;
        end
    end

    assign w_press = w_rel & r_armed & ~w_locked;

    always_comb begin
        w_pw_sel = bus.PW1;
        w_adv    = ST_S2;
        case (r_state)
            ST_S2: begin
                w_pw_sel = bus.PW2;
                w_adv    = ST_S3;
            end
            ST_S3: begin
                w_pw_sel = bus.PW3;
                w_adv    = ST_IDLE;
            end
            default: begin
                w_pw_sel = bus.PW1;
                w_adv    = ST_S2;
            end
        endcase
    end

    assign w_mm      = r_mismatch | (bus.D != w_pw_sel);
    assign w_cnt_inc = (r_fail_cnt >= MAX_CNT) ? r_fail_cnt : r_fail_cnt + 2'd1;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state    <= ST_IDLE;
            r_mismatch <= 1'b0;
            r_fail     <= 1'b0;
            r_fail_cnt <= 2'd0;
            r_create_q <= 1'b0;
            r_mode     <= 1'b0;
        end else begin
            r_fail     <= 1'b0;
            r_create_q <= bus.CREATE;
            case (r_state)
                ST_IDLE: begin
                    if (w_press) begin
                        r_state    <= ST_S1;
                        r_mismatch <= 1'b0;
                        r_mode     <= bus.CREATE;
                    end
                end
                ST_S1, ST_S2, ST_S3: begin
                    if (bus.CREATE != r_mode) begin
                        r_state    <= ST_IDLE;
                        r_mismatch <= 1'b0;
                    end else if (w_press) begin
                        if (r_mode) begin
                            r_state <= w_adv;
                        end else if (r_state != ST_S3) begin
                            r_state    <= w_adv;
                            r_mismatch <= w_mm;
                        end else if (!w_mm) begin
                            r_state    <= ST_OPEN;
                            r_mismatch <= 1'b0;
                            r_fail_cnt <= 2'd0;
                        end else begin
                            r_fail     <= 1'b1;
                            r_mismatch <= 1'b0;
                            r_fail_cnt <= w_cnt_inc;
`ifdef LOCKOUT_TIMER_EN
                            r_state    <= (w_cnt_inc == MAX_CNT) ? ST_LOCK : ST_IDLE;
`else
                            r_state    <= ST_IDLE;
`endif
                        end
                    end
                end
                ST_OPEN: begin
                    // Re-programming is only allowed from IDLE, so a CREATE flip relocks first.
                    if (w_press || (bus.CREATE && !r_create_q)) begin
                        r_state <= ST_IDLE;
                    end
                end
`ifdef LOCKOUT_TIMER_EN
                ST_LOCK: begin
                    if (w_lock_done) begin
                        r_state    <= ST_IDLE;
                        r_fail_cnt <= 2'd0;
                    end
                end
`endif
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.STAGE      = stage_of(r_state);
    assign bus.UNLOCKED   = (r_state == ST_OPEN);
    assign bus.FAIL       = r_fail;
    assign bus.FAIL_CNT   = r_fail_cnt;
    assign bus.LOCKED_OUT = w_locked;
endmodule

// File: tb/tb_pass_check.sv
// Scoreboard bench for pass_check: expected outputs queued per press, popped after settling.
module tb_pass_check;
    import pass_check_pkg::*;

    localparam int PW_W        = 3;
    localparam int MAX_FAILS   = 3;
    localparam int LOCK_CYCLES = 16;

    typedef struct {
        int stage;
        int unl;
        int fails;
        int cnt;
        int lo;
    } exp_t;

    logic CLK = 1'b0;
    logic RST;

    exp_t sb[$];
    int   n_cmp       = 0;
    int   n_bad       = 0;
    int   fail_pulses = 0;
    int   lock_hi     = 0;
    int   cur_stage   = 0;

    always #5 CLK = ~CLK;

    pass_check_if #(.PW_W(PW_W)) bus ();

    pass_check #(
        .PW_W        (PW_W),
        .MAX_FAILS   (MAX_FAILS)
`ifdef LOCKOUT_TIMER_EN
        ,
        .LOCK_CYCLES (LOCK_CYCLES)
`endif
    ) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    always @(negedge CLK) begin
        if (bus.FAIL === 1'b1) fail_pulses++;
        if (bus.LOCKED_OUT === 1'b1) lock_hi++;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic compare_out(input string tag);
        exp_t e;
        chk({tag, ".sb_nonempty"}, 32'(sb.size() > 0), 1);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk({tag, ".stage"},    32'(bus.STAGE),      e.stage);
            chk({tag, ".unlocked"}, 32'(bus.UNLOCKED),   e.unl);
            chk({tag, ".fail_n"},   fail_pulses,         e.fails);
            chk({tag, ".fail_cnt"}, 32'(bus.FAIL_CNT),   e.cnt);
            chk({tag, ".locked"},   32'(bus.LOCKED_OUT), e.lo);
        end
    endtask

    task automatic press(input int d, input string tag, input bit lat);
        @(negedge CLK);
        bus.D       = 3'(d);
        fail_pulses = 0;
        bus.EN      = 1'b1;
        repeat (4) begin
            @(negedge CLK);
            chk({tag, ".hold"}, 32'(bus.STAGE), cur_stage);
        end
        bus.EN = 1'b0;
        if (lat) begin
            for (int i = 0; i < 4; i++) begin
                @(negedge CLK);
                chk({tag, ".lat"}, 32'(bus.UNLOCKED), 32'(i == 3));
            end
            @(negedge CLK);
        end else begin
            repeat (5) @(negedge CLK);
        end
    endtask

    task automatic step(input int d, input string tag, input int stage, input int unl,
                        input int fails, input int cnt, input int lo, input bit lat);
        exp_t e;
        e = '{stage: stage, unl: unl, fails: fails, cnt: cnt, lo: lo};
        sb.push_back(e);
        press(d, tag, lat);
        compare_out(tag);
        cur_stage = stage;
    endtask

    task automatic settle(input string tag, input int stage, input int unl,
                          input int fails, input int cnt, input int lo);
        exp_t e;
        e = '{stage: stage, unl: unl, fails: fails, cnt: cnt, lo: lo};
        sb.push_back(e);
        fail_pulses = 0;
        repeat (6) @(negedge CLK);
        compare_out(tag);
        cur_stage = stage;
    endtask

    task automatic set_create(input logic v);
        @(negedge CLK);
        bus.CREATE = v;
    endtask

    task automatic good_code(input string tag, input int cnt0);
        step(0, {tag, "0"}, 1, 0, 0, cnt0, 0, 1'b0);
        step(5, {tag, "1"}, 2, 0, 0, cnt0, 0, 1'b0);
        step(2, {tag, "2"}, 3, 0, 0, cnt0, 0, 1'b0);
        step(7, {tag, "3"}, 0, 1, 0, 0,    0, 1'b1);
    endtask

    task automatic bad_code(input string tag, input int cnt0, input int cnt1, input int lo1);
        step(0, {tag, "0"}, 1, 0, 0, cnt0, 0,   1'b0);
        step(1, {tag, "1"}, 2, 0, 0, cnt0, 0,   1'b0);
        step(1, {tag, "2"}, 3, 0, 0, cnt0, 0,   1'b0);
        step(1, {tag, "3"}, 0, 0, 1, cnt1, lo1, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        RST        = 1'b1;
        bus.EN     = 1'b0;
        bus.CREATE = 1'b0;
        bus.D      = '0;
        bus.PW1    = 3'd5;
        bus.PW2    = 3'd2;
        bus.PW3    = 3'd7;
        repeat (3) @(negedge CLK);
        chk("rst.stage",    32'(bus.STAGE),      0);
        chk("rst.unlocked", 32'(bus.UNLOCKED),   0);
        chk("rst.fail",     32'(bus.FAIL),       0);
        chk("rst.fail_cnt", 32'(bus.FAIL_CNT),   0);
        chk("rst.locked",   32'(bus.LOCKED_OUT), 0);
        RST = 1'b0;
        repeat (2) @(negedge CLK);

        // create walk
        set_create(1'b1);
        repeat (2) @(negedge CLK);
        step(0, "cw0", 1, 0, 0, 0, 0, 1'b0);
        step(5, "cw1", 2, 0, 0, 0, 0, 1'b0);
        step(2, "cw2", 3, 0, 0, 0, 0, 1'b0);
        step(7, "cw3", 0, 0, 0, 0, 0, 1'b0);
        set_create(1'b0);
        repeat (2) @(negedge CLK);

        // correct code, relock by press
        good_code("ok", 0);
        step(0, "relock", 0, 0, 0, 0, 0, 1'b0);

        // wrong middle digit
        step(0, "wm0", 1, 0, 0, 0, 0, 1'b0);
        step(5, "wm1", 2, 0, 0, 0, 0, 1'b0);
        step(3, "wm2", 3, 0, 0, 0, 0, 1'b0);
        step(7, "wm3", 0, 0, 1, 1, 0, 1'b0);

        // abort in S2 with mismatch recorded, then a clean entry unlocks
        step(0, "ab0", 1, 0, 0, 1, 0, 1'b0);
        step(3, "ab1", 2, 0, 0, 1, 0, 1'b0);
        set_create(1'b1);
        settle("abort", 0, 0, 0, 1, 0);
        set_create(1'b0);
        settle("abort_idle", 0, 0, 0, 1, 0);
        good_code("ok2_", 1);

        // CREATE rising while open relocks
        set_create(1'b1);
        settle("open_create", 0, 0, 0, 0, 0);
        set_create(1'b0);
        settle("open_create_idle", 0, 0, 0, 0, 0);

        // EN glitches: straddling one edge gives exactly one release, between edges none
        @(negedge CLK);
        #3 bus.EN = 1'b1;
        #4 bus.EN = 1'b0;
        settle("glitch_edge", 1, 0, 0, 0, 0);
        @(negedge CLK);
        #1 bus.EN = 1'b1;
        #2 bus.EN = 1'b0;
        settle("glitch_narrow", 1, 0, 0, 0, 0);
        set_create(1'b1);
        settle("glitch_abort", 0, 0, 0, 0, 0);
        set_create(1'b0);
        settle("glitch_idle", 0, 0, 0, 0, 0);

        // three bad codes
        bad_code("bc1_", 0, 1, 0);
        bad_code("bc2_", 1, 2, 0);
`ifdef LOCKOUT_TIMER_EN
        bad_code("bc3_", 2, 3, 1);
        step(0, "lk_press", 0, 0, 0, 3, 1, 1'b0);
        begin
            int w;
            w = 0;
            while (bus.LOCKED_OUT === 1'b1 && w < 200) begin
                @(negedge CLK);
                w++;
            end
            chk("lock_release_in_budget", 32'(w < 200), 1);
        end
        chk("lock_cycles", lock_hi, LOCK_CYCLES);
        settle("post_lock", 0, 0, 0, 0, 0);
        step(0, "post_lock_start", 1, 0, 0, 0, 0, 1'b0);
        set_create(1'b1);
        settle("post_lock_abort", 0, 0, 0, 0, 0);
        set_create(1'b0);
        settle("post_lock_idle", 0, 0, 0, 0, 0);
`else
        bad_code("bc3_", 2, 3, 0);
        bad_code("bc4_", 3, 3, 0);
        chk("never_locked", lock_hi, 0);
        good_code("ok3_", 3);
        step(0, "relock3", 0, 0, 0, 0, 0, 1'b0);
`endif

        // reset in the middle of S2
        bad_code("rsb", 0, 1, 0);
        step(0, "rs0", 1, 0, 0, 1, 0, 1'b0);
        step(5, "rs1", 2, 0, 0, 1, 0, 1'b0);
        @(negedge CLK);
        #2 RST = 1'b1;
        #1;
        chk("midrst.stage",    32'(bus.STAGE),      0);
        chk("midrst.unlocked", 32'(bus.UNLOCKED),   0);
        chk("midrst.fail",     32'(bus.FAIL),       0);
        chk("midrst.fail_cnt", 32'(bus.FAIL_CNT),   0);
        chk("midrst.locked",   32'(bus.LOCKED_OUT), 0);
        @(negedge CLK);
        RST = 1'b0;
        cur_stage = 0;
        settle("after_rst", 0, 0, 0, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
